// File: rtl/conv_scheduler_if.sv
// Handshake bundle between the convolution job controller, its requester and the memory/engine blocks.
// The master drives the job request and capture indication; the slave (the scheduler) drives the strobes and status.
interface conv_scheduler_if;
  logic       start_i;
  logic [2:0] mode_mask_i;
  logic       done_capture_i;
  logic       run_valid_o;
  logic       PE_valid_o;
  logic       SA_3x3_valid_o;
  logic       SA_2x2_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [1:0] phase_o;

  modport master (
    output start_i, mode_mask_i, done_capture_i,
    input  run_valid_o, PE_valid_o, SA_3x3_valid_o, SA_2x2_valid_o,
    input  busy_o, done_o, err_o, phase_o
  );

  modport slave (
    input  start_i, mode_mask_i, done_capture_i,
    output run_valid_o, PE_valid_o, SA_3x3_valid_o, SA_2x2_valid_o,
    output busy_o, done_o, err_o, phase_o
  );
endinterface

// File: rtl/conv_scheduler.sv
// Sequences one convolution job: operand load, capture wait with timeout, then the enabled
// compute phases (PE, SA 3x3, SA 2x2) separated by single gap cycles, ending in a done pulse.
module conv_scheduler #(
  parameter int LOAD_CYC    = 3,
  parameter int COMPUTE_CYC = 6,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             reset,
  conv_scheduler_if.slave  bus
);

  localparam int MAX_LC  = (LOAD_CYC > COMPUTE_CYC) ? LOAD_CYC : COMPUTE_CYC;
  localparam int MAX_CYC = (MAX_LC > TIMEOUT) ? MAX_LC : TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] CMP_LAST  = CNT_W'(COMPUTE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CAP,
    S_PE,
    S_SA3,
    S_SA2,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           gap_tgt;
  state_t           gap_tgt_nxt;
  state_t           follow_on;
  logic [CNT_W-1:0] cnt;
  logic             cap_seen;
  logic [2:0]       mask;
  logic             start_acc;

  // First enabled phase at or after position idx (0 PE, 1 SA3, 2 SA2); DONE when none remain.
  function automatic state_t phase_from(input logic [2:0] m, input logic [1:0] idx);
    state_t r;
    r = S_DONE;
    if (m[2] && (idx <= 2'd2)) r = S_SA2;
    if (m[1] && (idx <= 2'd1)) r = S_SA3;
    if (m[0] && (idx == 2'd0)) r = S_PE;
    return r;
  endfunction

  function automatic logic [1:0] phase_code(input state_t s);
    logic [1:0] r;
    case (s)
      S_PE:    r = 2'd1;
      S_SA3:   r = 2'd2;
      S_SA2:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign start_acc = ((state == S_IDLE) || (state == S_ERR)) && bus.start_i;

  always_comb begin
    state_nxt   = state;
    gap_tgt_nxt = gap_tgt;
    follow_on   = S_DONE;
    case (state)
      S_IDLE, S_ERR: begin
        if (bus.start_i) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (cnt == LOAD_LAST) begin
          if (cap_seen || bus.done_capture_i) state_nxt = phase_from(mask, 2'd0);
          else                                state_nxt = S_WAIT_CAP;
        end
      end
      S_WAIT_CAP: begin
        // A capture arriving in the final allowed cycle beats the timeout.
        if (bus.done_capture_i)   state_nxt = phase_from(mask, 2'd0);
        else if (cnt == TO_LAST)  state_nxt = S_ERR;
      end
      S_PE: begin
        if (cnt == CMP_LAST) begin
          follow_on = phase_from(mask, 2'd1);
          if (follow_on == S_DONE) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt   = S_GAP;
            gap_tgt_nxt = follow_on;
          end
        end
      end
      S_SA3: begin
        if (cnt == CMP_LAST) begin
          follow_on = phase_from(mask, 2'd2);
          if (follow_on == S_DONE) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt   = S_GAP;
            gap_tgt_nxt = follow_on;
          end
        end
      end
      S_SA2: begin
        if (cnt == CMP_LAST) state_nxt = S_DONE;
      end
      S_GAP:   state_nxt = gap_tgt;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      gap_tgt            <= S_IDLE;
      cnt                <= '0;
      cap_seen           <= 1'b0;
      mask               <= 3'b000;
      bus.run_valid_o    <= 1'b0;
      bus.PE_valid_o     <= 1'b0;
      bus.SA_3x3_valid_o <= 1'b0;
      bus.SA_2x2_valid_o <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.done_o         <= 1'b0;
      bus.err_o          <= 1'b0;
      bus.phase_o        <= 2'd0;
    end else begin
      state   <= state_nxt;
      gap_tgt <= gap_tgt_nxt;

      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (start_acc) begin
        mask     <= bus.mode_mask_i;
        cap_seen <= 1'b0;
      end else if ((state == S_LOAD) && bus.done_capture_i) begin
        cap_seen <= 1'b1;
      end

      bus.run_valid_o    <= (state_nxt == S_LOAD);
      bus.PE_valid_o     <= (state_nxt == S_PE);
      bus.SA_3x3_valid_o <= (state_nxt == S_SA3);
      bus.SA_2x2_valid_o <= (state_nxt == S_SA2);
      bus.busy_o         <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
      bus.done_o         <= (state_nxt == S_DONE);
      bus.err_o          <= (state_nxt == S_ERR);
      bus.phase_o        <= phase_code(state_nxt);
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: a job-level model expands each request into the
// expected per-cycle output vectors, and a negedge monitor pops and compares them.
module tb_conv_scheduler;

  localparam int LOAD_CYC    = 3;
  localparam int COMPUTE_CYC = 6;
  localparam int TIMEOUT     = 15;

  typedef logic [8:0] vec_t; // {run, pe, sa3, sa2, busy, done, err, phase[1:0]}

  localparam vec_t V_IDLE = 9'b000000000;
  localparam vec_t V_LOAD = 9'b100010000;
  localparam vec_t V_WAIT = 9'b000010000;
  localparam vec_t V_GAP  = 9'b000010000;
  localparam vec_t V_PE   = 9'b010010001;
  localparam vec_t V_SA3  = 9'b001010010;
  localparam vec_t V_SA2  = 9'b000110011;
  localparam vec_t V_DONE = 9'b000011000;
  localparam vec_t V_ERR  = 9'b000000100;

  logic clk = 1'b0;
  logic reset;

  conv_scheduler_if bus();

  conv_scheduler #(
    .LOAD_CYC   (LOAD_CYC),
    .COMPUTE_CYC(COMPUTE_CYC),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  vec_t trace[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_err = 1'b0;

  function automatic vec_t actual_vec();
    return {bus.run_valid_o, bus.PE_valid_o, bus.SA_3x3_valid_o, bus.SA_2x2_valid_o,
            bus.busy_o, bus.done_o, bus.err_o, bus.phase_o};
  endfunction

  always @(negedge clk) begin : monitor
    vec_t e;
    vec_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_vec t=%0t actual=%b required=%b (run,pe,sa3,sa2,busy,done,err,phase)",
                 $time, a, e);
      end
    end
  end

  function automatic vec_t phase_vec(input int p);
    case (p)
      0:       return V_PE;
      1:       return V_SA3;
      default: return V_SA2;
    endcase
  endfunction

  // Job-level model: entry 0 is the cycle the request is presented, entry k the k-th cycle after.
  // c is the cycle (1 = first load cycle) in which the capture pulse is given; 0 means never.
  task automatic build_trace(input logic [2:0] m, input int c, output int cap_end, output bit err_out);
    int waits;
    bit first;
    trace.delete();
    trace.push_back(model_err ? V_ERR : V_IDLE);
    repeat (LOAD_CYC) trace.push_back(V_LOAD);
    err_out = 1'b0;
    if (c >= 1 && c <= LOAD_CYC)                          waits = 0;
    else if (c > LOAD_CYC && (c - LOAD_CYC) <= TIMEOUT)   waits = c - LOAD_CYC;
    else begin
      err_out = 1'b1;
      waits   = TIMEOUT;
    end
    repeat (waits) trace.push_back(V_WAIT);
    if (err_out) begin
      trace.push_back(V_ERR);
      cap_end = trace.size();
    end else begin
      cap_end = trace.size() - 1;
      first = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (m[p]) begin
          if (!first) trace.push_back(V_GAP);
          repeat (COMPUTE_CYC) trace.push_back(phase_vec(p));
          first = 1'b0;
        end
      end
      trace.push_back(V_DONE);
    end
  endtask

  task automatic run_job(input logic [2:0] m, input int c, input bit hold);
    int cap_end;
    bit job_err;
    build_trace(m, c, cap_end, job_err);
    foreach (trace[i]) exp_q.push_back(trace[i]);
    bus.start_i        = 1'b1;
    bus.mode_mask_i    = m;
    bus.done_capture_i = 1'b0;
    for (int k = 1; k < trace.size(); k++) begin
      @(posedge clk); #1;
      bus.mode_mask_i    = 3'($urandom);
      bus.start_i        = (trace[k] == V_ERR) ? 1'b0 : (hold || ($urandom_range(0, 3) == 0));
      bus.done_capture_i = (k == c) || ((k > cap_end) && ($urandom_range(0, 2) == 0));
    end
    @(posedge clk); #1;
    bus.start_i        = 1'b0;
    bus.done_capture_i = 1'b0;
    model_err          = job_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_err ? V_ERR : V_IDLE);
      bus.start_i        = 1'b0;
      bus.done_capture_i = 1'($urandom);
      bus.mode_mask_i    = 3'($urandom);
      @(posedge clk); #1;
    end
    bus.done_capture_i = 1'b0;
  endtask

  // Full-mask job cut by an asynchronous reset in the third SA 3x3 cycle (cycle 13).
  task automatic reset_mid_sa3();
    int cap_end;
    bit job_err;
    build_trace(3'b111, 2, cap_end, job_err);
    for (int i = 0; i < 13; i++) exp_q.push_back(trace[i]);
    repeat (3) exp_q.push_back(V_IDLE);
    bus.start_i        = 1'b1;
    bus.mode_mask_i    = 3'b111;
    bus.done_capture_i = 1'b0;
    for (int k = 1; k < 13; k++) begin
      @(posedge clk); #1;
      bus.start_i        = 1'b0;
      bus.done_capture_i = (k == 2);
    end
    @(posedge clk); #1;
    bus.done_capture_i = 1'b0;
    #2 reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    reset     = 1'b1;
    model_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit (queue=%0d)", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   r;
    int   c;
    logic [2:0] m;
    reset              = 1'b0;
    bus.start_i        = 1'b0;
    bus.mode_mask_i    = 3'b000;
    bus.done_capture_i = 1'b0;
    exp_q.push_back(V_IDLE);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_job(3'b111, 2, 1'b0);
    run_job(3'b101, 5, 1'b0);
    run_job(3'b111, 0, 1'b0);
    idle(3);
    run_job(3'b011, 3, 1'b0);
    run_job(3'b000, 1, 1'b0);
    run_job(3'b010, 2, 1'b1);
    run_job(3'b100, 3, 1'b0);
    run_job(3'b001, 18, 1'b0);
    run_job(3'b110, 19, 1'b0);
    run_job(3'b001, 4, 1'b0);
    reset_mid_sa3();
    run_job(3'b111, 1, 1'b0);

    for (int j = 0; j < 25; j++) begin
      m = 3'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      c = 0;
      else if (r == 1) c = $urandom_range(16, 19);
      else             c = $urandom_range(1, 10);
      run_job(m, c, ($urandom_range(0, 4) == 0));
      if (model_err && ($urandom_range(0, 1) == 0)) idle(2);
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 Parameter LOAD_CYC, default 3: cycles run_valid_o is held high per job.
REQ-002 Parameter COMPUTE_CYC, default 6: cycles each compute valid is held high.
REQ-003 Parameter TIMEOUT, default 15: maximum WAIT_CAP cycles before error.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start_i  in  1  job request, sampled only in IDLE or ERR.
REQ-007 mode_mask_i  in  3  enabled phases: bit0 PE, bit1 SA_3x3, bit2 SA_2x2; latched on accepted start.
REQ-008 done_capture_i  in  1  operand-capture-complete indication from the memory block.
REQ-009 run_valid_o  out  1  operand-load strobe to the memory block.
REQ-010 PE_valid_o, SA_3x3_valid_o, SA_2x2_valid_o  out  1 each  result-capture window for the corresponding engine.
REQ-011 busy_o  out  1  job in progress.
REQ-012 done_o  out  1  one-cycle job-complete pulse.
REQ-013 err_o  out  1  sticky capture-timeout flag.
REQ-014 phase_o  out  2  current compute phase: 0 none, 1 PE, 2 SA_3x3, 3 SA_2x2.

Function
REQ-015 The block SHALL implement a Moore FSM with states IDLE, LOAD, WAIT_CAP, PE, SA3, SA2, GAP, DONE and ERR; all outputs SHALL be registered or decoded from the state register only.
REQ-016 Start: in IDLE or ERR, start_i=1 at an edge SHALL enter LOAD, latch mode_mask_i, clear err_o and clear cap_seen.
REQ-017 start_i SHALL be ignored in every other state; the latched mask SHALL NOT change mid-job.
REQ-018 LOAD SHALL assert run_valid_o for exactly LOAD_CYC cycles.
REQ-019 cap_seen SHALL set when done_capture_i=1 in LOAD.
REQ-020 At the end of LOAD the FSM SHALL go to the first enabled phase if cap_seen or done_capture_i is 1; otherwise it SHALL go to WAIT_CAP.
REQ-021 WAIT_CAP: done_capture_i=1 SHALL move to the first enabled phase at the next edge.
REQ-022 WAIT_CAP: after TIMEOUT consecutive cycles without done_capture_i the FSM SHALL enter ERR; done_capture_i in the TIMEOUT-th cycle SHALL win over the timeout.
REQ-023 Phase order SHALL be PE, then SA3, then SA2; disabled phases SHALL be skipped with no cycles spent.
REQ-024 Each enabled phase SHALL assert only its own valid output for exactly COMPUTE_CYC cycles, with phase_o showing that phase.
REQ-025 One GAP cycle (all valids 0, phase_o=0) SHALL separate consecutive enabled phases; there SHALL be no GAP after the last phase.
REQ-026 After the last enabled phase the FSM SHALL enter DONE, which SHALL last one cycle with done_o=1 and then return to IDLE.
REQ-027 A mask of 0 SHALL go from capture directly to DONE.
REQ-028 At most one of run_valid_o, PE_valid_o, SA_3x3_valid_o and SA_2x2_valid_o SHALL be 1 in any cycle.
REQ-029 busy_o SHALL be 1 in LOAD, WAIT_CAP, PE, SA3, SA2, GAP and DONE, and 0 in IDLE and ERR.
REQ-030 ERR SHALL hold err_o=1 with all valids 0 until an accepted start.
REQ-031 The shared cycle counter SHALL be sized as clog2(max(LOAD_CYC, COMPUTE_CYC, TIMEOUT)+1) bits.
REQ-032 The cycle counter SHALL reload to 0 on every state change and SHALL never wrap within a state.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, cap_seen 0 and latched mask 0.
REQ-034 reset=0 SHALL immediately drive every output to 0, including err_o and phase_o.
REQ-035 Reset asserted mid-job SHALL abandon the job with no done_o pulse.
REQ-036 After reset deassertion the first edge SHALL sample start_i normally.

Verification
REQ-037 Defaults, mask=3'b111, start at edge 0, done_capture_i pulsed in LOAD cycle 2 -> run_valid_o cycles 1-3; PE_valid_o 4-9; gap 10; SA_3x3_valid_o 11-16; gap 17; SA_2x2_valid_o 18-23; done_o cycle 24 only; busy_o cycles 1-24.
REQ-038 mask=3'b101, done_capture_i 2 cycles after LOAD ends -> WAIT_CAP 2 cycles; PE window 6 cycles; one gap; SA_2x2 window 6 cycles; SA_3x3_valid_o never 1; done_o once.
REQ-039 done_capture_i never asserted -> exactly 15 WAIT_CAP cycles, then err_o=1, busy_o=0 and no compute valid; a later start clears err_o and runs normally.
REQ-040 mask=3'b000 -> run_valid_o for 3 cycles, then done_o one cycle after capture, with no compute valids.
REQ-041 start_i held high through a job -> exactly one job runs; a new job starts at the edge after DONE (IDLE sampled).
REQ-042 reset driven low asynchronously mid-SA3 -> all outputs 0 before the next edge; no done_o; normal job after release.
